ntr_led_ctrl: RTL and testbench

NTR_LED_CTRL -- requirements
Module: ntr_led_ctrl

---
 rtl/ntr_pkg.sv | 20 ++
 rtl/ntr_sync_edge.sv | 29 ++
 rtl/ntr_led_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ntr_led_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ntr_pkg.sv
// rtl/ntr_pkg.sv - shared state encodings and LED mode codes for the NTR LED controller.
package ntr_pkg;

    localparam int BYTE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        EXEC  = 2'd2,
        DRAIN = 2'd3
    } ntr_state_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SET  = 2'd1,
        CLR  = 2'd2,
        TGL  = 2'd3
    } led_mode_t;

endpackage

// File: rtl/ntr_sync_edge.sv
// rtl/ntr_sync_edge.sv - multi-flop synchroniser with rising-edge detector.
module ntr_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ntr_led_ctrl.sv
// rtl/ntr_led_ctrl.sv - NTR bus command receiver driving an LED state register.
module ntr_led_ctrl
    import ntr_pkg::*;
#(
    parameter int         NUM_LEDS    = 4,
    parameter int         CMD_BYTES   = 8,
    parameter logic [7:0] OPCODE      = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ntr_clk,
    input  logic                  ntr_cs1,
    input  logic [7:0]            ntr_data,
    output logic [NUM_LEDS-1:0]   leds,
    output logic                  cmd_valid,
    output logic [BYTE_CNT_W-1:0] byte_count,
    output logic [7:0]            cmd_count,
    output logic                  err
);

    localparam logic [BYTE_CNT_W-1:0] LAST_SLOT  = BYTE_CNT_W'(CMD_BYTES - 1);
    localparam logic [2:0]            FLUSH_DONE = 3'(SYNC_STAGES);

    logic nclk_level, nclk_rise;
    logic cs_level, cs_rise;

    ntr_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_clk (
        .clk      (clk),
        .rst      (rst),
        .async_in (ntr_clk),
        .level    (nclk_level),
        .rise     (nclk_rise)
    );

    ntr_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk      (clk),
        .rst      (rst),
        .async_in (ntr_cs1),
        .level    (cs_level),
        .rise     (cs_rise)
    );

    ntr_state_t            state_q, state_next;
    logic                  start, store_en, exec_en, abort, overrun;
    logic [2:0]            flush_cnt;
    logic                  armed_q;
    logic [7:0]            byte0_q, byte1_q;
    logic [NUM_LEDS-1:0]   mask_q;
    logic [NUM_LEDS-1:0]   leds_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // A cs1 rise always takes priority over an ntr_clk edge seen in the same cycle.
    always_comb begin
        state_next = state_q;
        start      = 1'b0;
        store_en   = 1'b0;
        exec_en    = 1'b0;
        abort      = 1'b0;
        overrun    = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !cs_level) begin
                    state_next = RECV;
                    start      = 1'b1;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (nclk_rise) begin
                    store_en = 1'b1;
                    if (byte_count == LAST_SLOT) begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                exec_en    = 1'b1;
                overrun    = nclk_rise & ~cs_level;
                state_next = DRAIN;
            end
            DRAIN: begin
                overrun = nclk_rise & ~cs_level;
                if (cs_level) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        leds_mode = leds;
        case (led_mode_t'(byte1_q[1:0]))
            LOAD:    leds_mode = mask_q;
            SET:     leds_mode = leds | mask_q;
            CLR:     leds_mode = leds & ~mask_q;
            TGL:     leds_mode = leds ^ mask_q;
            default: leds_mode = leds;
        endcase
    end

    // After reset the bus must be seen at rest (cs1 high, ntr_clk low) once the
    // synchronisers have flushed, so a chip select held low through reset is not taken as a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds       <= '0;
            cmd_valid  <= 1'b0;
            byte_count <= '0;
            cmd_count  <= '0;
            err        <= 1'b0;
            flush_cnt  <= '0;
            armed_q    <= 1'b0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            mask_q     <= '0;
        end else begin
            cmd_valid <= exec_en;
            if (flush_cnt != FLUSH_DONE) begin
                flush_cnt <= flush_cnt + 3'd1;
            end
            if (flush_cnt == FLUSH_DONE && cs_level && !nclk_level) begin
                armed_q <= 1'b1;
            end
            if (start) begin
                byte_count <= '0;
            end
            if (store_en) begin
                byte_count <= byte_count + 1'b1;
                if (byte_count == '0) begin
                    byte0_q <= ntr_data;
                end
                if (byte_count == BYTE_CNT_W'(1)) begin
                    byte1_q <= ntr_data;
                end
                if (byte_count == LAST_SLOT) begin
                    mask_q <= ntr_data[NUM_LEDS-1:0];
                end
            end
            if (abort || overrun) begin
                err <= 1'b1;
            end
            if (exec_en) begin
                cmd_count <= cmd_count + 8'd1;
                if (byte0_q == OPCODE) begin
                    if (byte1_q[7:2] != 6'd0) begin
                        err <= 1'b1;
                    end else begin
                        leds <= leds_mode;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ntr_led_ctrl.sv
// tb/tb_ntr_led_ctrl.sv - self-checking bench for ntr_led_ctrl with a transaction-level model.
module tb_ntr_led_ctrl;

    localparam int         NUM_LEDS    = 4;
    localparam int         CMD_BYTES   = 8;
    localparam logic [7:0] OPCODE      = 8'hFF;
    localparam int         SYNC_STAGES = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ntr_clk = 1'b0;
    logic                ntr_cs1 = 1'b1;
    logic [7:0]          ntr_data = 8'h00;
    logic [NUM_LEDS-1:0] leds;
    logic                cmd_valid;
    logic [3:0]          byte_count;
    logic [7:0]          cmd_count;
    logic                err;

    ntr_led_ctrl #(
        .NUM_LEDS    (NUM_LEDS),
        .CMD_BYTES   (CMD_BYTES),
        .OPCODE      (OPCODE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ntr_clk    (ntr_clk),
        .ntr_cs1    (ntr_cs1),
        .ntr_data   (ntr_data),
        .leds       (leds),
        .cmd_valid  (cmd_valid),
        .byte_count (byte_count),
        .cmd_count  (cmd_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int                  checks = 0;
    int                  passes = 0;
    int                  pulses = 0;
    int                  exp_pulses = 0;
    logic [NUM_LEDS-1:0] exp_leds = '0;
    logic [7:0]          exp_cnt = 8'd0;
    logic                exp_err = 1'b0;
    bit                  settled = 1'b0;
    logic [NUM_LEDS-1:0] prev_leds = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Outcome of one complete command, straight from the decode table.
    function automatic void model_cmd(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] mask);
        logic [NUM_LEDS-1:0] m;
        m = mask[NUM_LEDS-1:0];
        exp_cnt    = exp_cnt + 8'd1;
        exp_pulses = exp_pulses + 1;
        if (b0 == OPCODE) begin
            if (b1[7:2] != 6'd0) exp_err = 1'b1;
            else begin
                case (b1[1:0])
                    2'd0:    exp_leds = m;
                    2'd1:    exp_leds = exp_leds | m;
                    2'd2:    exp_leds = exp_leds & ~m;
                    default: exp_leds = exp_leds ^ m;
                endcase
            end
        end
    endfunction

    function automatic logic [7:0] byte_at(input int i, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] mask);
        if (i == 0) return b0;
        if (i == 1) return b1;
        if (i == CMD_BYTES - 1) return mask;
        return 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ntr_byte(input logic [7:0] b);
        ntr_data = b;
        ntr_clk  = 1'b1;
        tick(4);
        ntr_clk  = 1'b0;
        tick(4);
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] mask,
                        input int n, input int exp_bc);
        settled = 1'b0;
        ntr_cs1 = 1'b0;
        if (n >= CMD_BYTES) model_cmd(b0, b1, mask);
        if (n != CMD_BYTES) exp_err = 1'b1;
        tick(4);
        for (int i = 0; i < n; i++) ntr_byte(byte_at(i, b0, b1, mask));
        check("byte_count_before_cs_high", int'(byte_count), exp_bc);
        ntr_cs1 = 1'b1;
        tick(6);
        settled = 1'b1;
        check("cmd_valid_pulses", pulses, exp_pulses);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_leds = '0;
        end else begin
            if (cmd_valid) begin
                pulses++;
                check("leds_with_cmd_valid", int'(leds), int'(exp_leds));
            end else begin
                check("leds_stable_without_cmd_valid", int'(leds), int'(prev_leds));
            end
            if (settled) begin
                check("leds", int'(leds), int'(exp_leds));
                check("err", int'(err), int'(exp_err));
                check("cmd_count", int'(cmd_count), int'(exp_cnt));
            end
            prev_leds = leds;
        end
    end

    initial begin
        tick(3);
        check("reset_leds", int'(leds), 0);
        check("reset_cmd_count", int'(cmd_count), 0);
        check("reset_err", int'(err), 0);
        check("reset_cmd_valid", int'(cmd_valid), 0);
        check("reset_byte_count", int'(byte_count), 0);
        rst = 1'b0;
        tick(4);
        settled = 1'b1;

        send(8'hFF, 8'h00, 8'h05, 8, 8);
        check("lit_load_leds", int'(leds), 5);
        check("lit_load_count", int'(cmd_count), 1);
        check("lit_load_pulses", pulses, 1);
        send(8'hFF, 8'h03, 8'h0F, 8, 8);
        check("lit_toggle_leds", int'(leds), 10);
        send(8'hFF, 8'h02, 8'h08, 8, 8);
        check("lit_clear_leds", int'(leds), 2);
        send(8'hFF, 8'h01, 8'h04, 8, 8);
        check("lit_set_leds", int'(leds), 6);
        send(8'h3C, 8'h00, 8'h0F, 8, 8);
        check("lit_other_opcode_leds", int'(leds), 6);
        check("lit_other_opcode_count", int'(cmd_count), 5);
        check("lit_other_opcode_err", int'(err), 0);

        send(8'hFF, 8'h00, 8'h0F, 5, 5);
        check("lit_abort_err", int'(err), 1);
        check("lit_abort_leds", int'(leds), 6);
        check("lit_abort_pulses", pulses, 5);

        settled = 1'b0;
        ntr_cs1 = 1'b0;
        tick(4);
        check("lit_byte_count_cleared", int'(byte_count), 0);
        for (int i = 0; i < 3; i++) ntr_byte(8'hFF);
        ntr_data = 8'hAA;
        ntr_clk  = 1'b1;
        ntr_cs1  = 1'b1;
        tick(6);
        check("lit_cs_rise_wins", int'(byte_count), 3);
        ntr_clk = 1'b0;
        tick(4);
        settled = 1'b1;

        send(8'hFF, 8'h01, 8'h01, 10, 8);
        check("lit_overrun_leds", int'(leds), 7);
        check("lit_overrun_byte_count", int'(byte_count), 8);

        settled = 1'b0;
        ntr_cs1 = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) ntr_byte(8'hFF);
        rst      = 1'b1;
        exp_leds = '0;
        exp_cnt  = 8'd0;
        exp_err  = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        ntr_byte(8'hFF);
        ntr_byte(8'h00);
        check("lit_no_start_after_reset", int'(byte_count), 0);
        ntr_cs1 = 1'b1;
        tick(6);
        settled = 1'b1;
        send(8'hFF, 8'h00, 8'h01, 8, 8);
        check("lit_post_reset_leds", int'(leds), 1);
        check("lit_post_reset_count", int'(cmd_count), 1);
        check("lit_post_reset_err", int'(err), 0);

        send(8'hFF, 8'h84, 8'h0F, 8, 8);
        check("lit_unknown_mode_err", int'(err), 1);
        check("lit_unknown_mode_leds", int'(leds), 1);
        check("lit_unknown_mode_count", int'(cmd_count), 2);

        for (int i = 0; i < 253; i++) send(8'h3C, 8'h00, 8'h00, 8, 8);
        check("lit_count_255", int'(cmd_count), 255);
        send(8'h3C, 8'h00, 8'h00, 8, 8);
        check("lit_count_wrap", int'(cmd_count), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
